vga_fb_pixel_pipe: RTL
======================

// Module: vga_fb_pixel_pipe
// PURPOSE
//  Parametrised successor to the hard-wired VGA pixel path: owns a writable 1bpp framebuffer
//  (linear, MSB = leftmost pixel), scales it to the active area and renders fg/bg colour.
//  Sits between sync_gen and the RGB/sync output pins. A clear engine and a valid/ready write port let firmware draw.
// PARAMETERS
//  H_ACTIVE   640   visible pixels per line
//  V_ACTIVE   480   visible lines per frame
//  SCALE      1     pixel replication factor in x and y; legal values 1, 2, 4
//  SYNC_IDLE  1'b1  inactive level of h_sync/v_sync driven during reset
//  Derived: FB_W=H_ACTIVE/SCALE, FB_H=V_ACTIVE/SCALE, ROW_B=FB_W/8, FB_BYTES=ROW_B*FB_H, ADDR_W=$clog2(FB_BYTES)
// PORTS
//  CLK_25      in   1       pixel clock; the only clock
//  Reset       in   1       synchronous, active-high
//  pixel_x     in   10      sync_gen column counter
//  pixel_y     in   10      sync_gen row counter
//  in_display  in   1       sync_gen active-area flag
//  h_sync_in   in   1       raw h_sync from sync_gen
//  v_sync_in   in   1       raw v_sync from sync_gen
//  wr_valid    in   1       write request
//  wr_ready    out  1       write accepted when wr_valid && wr_ready
//  wr_addr     in   ADDR_W  framebuffer byte address (row*ROW_B + col/8)
//  wr_data     in   8       8 pixels, bit7 leftmost
//  clear_req   in   1       start clearing the framebuffer to 0
//  clear_busy  out  1       clear in progress
//  mode        in   2       0 BITMAP, 1 INVERT, 2 CHECKER, 3 SOLID_BG
//  fg_color    in   12      {R,G,B} 4b each, for pixel=1
//  bg_color    in   12      {R,G,B} for pixel=0
//  RED/GREEN/BLUE out 4 each registered colour outputs
//  h_sync/v_sync  out 1 each  syncs delayed to match the colour path
// BEHAVIOUR
//  Reset: RED/GREEN/BLUE=0, h_sync=v_sync=SYNC_IDLE, clear_busy=0, wr_ready=1, FSM=IDLE, mode/colour shadows=0.
//   Framebuffer RAM is not reset.
//  Read pipeline, fixed latency 3: Q0->Q1 register fb_x=pixel_x>>log2(SCALE), fb_y likewise, addr=fb_y*ROW_B+fb_x[..:3],
//   bit=fb_x[2:0], in_display, syncs; Q1->Q2 RAM registered read; Q2->Q3 select bit (7-bit), apply mode, register RGB.
//   h_sync/v_sync/in_display are delayed through the same 3 stages, so colour and sync stay aligned.
//  Outside the active area (delayed in_display=0): RGB=0 regardless of mode.
//  Mode: 0 -> bit?fg:bg; 1 -> bit?bg:fg; 2 -> (fb_x[3]^fb_y[3])?fg:bg with no RAM dependence; 3 -> bg.
//  Shadows: mode, fg_color and bg_color are captured only when pixel_x==0 && pixel_y==0 (frame start), so there is
//   no mid-frame tearing. A change takes effect on the next frame.
//  Clear FSM: IDLE --clear_req--> CLEAR; CLEAR writes 8'h00 at clr_addr, clr_addr++ each cycle;
//   clr_addr==FB_BYTES-1 -> IDLE. Duration is exactly FB_BYTES cycles. clear_busy=1 in CLEAR.
//   clear_req while in CLEAR is ignored.
//  Write port: wr_ready = ~clear_busy (combinational from the state register). An accepted write lands in RAM on
//   the same edge. wr_addr>=FB_BYTES is accepted and dropped, with no wrap. A write that is not accepted must be held.
//  Read/write on the same address in the same cycle: the read returns the old data.
//  clear_req and wr_valid in the same cycle while IDLE: the write is accepted, then the clear starts next cycle.
//  Reset during CLEAR: FSM returns to IDLE and clr_addr=0. RAM is partially cleared, which is legal.
//  pixel_x>=H_ACTIVE or pixel_y>=V_ACTIVE: the address is clamped to 0. RGB is blanked anyway.
// STRUCTURE
//  vga_pkg: mode_t enum (BITMAP, INVERT, CHECKER, SOLID_BG), color_t packed {r,g,b}, H_ACTIVE/V_ACTIVE defaults,
//   clear FSM state enum.
//  Sub-module fb_ram: simple dual-port, one write port, one registered read port, DEPTH=FB_BYTES, WIDTH=8,
//   read-old-on-collision.
//  Everything else is inline: the address stage, the delay lines, the colour mux and the clear FSM.
// TESTING
//  1 Reset held 5 cycles -> RGB=0, h_sync=v_sync=1, wr_ready=1, clear_busy=0.
//  2 SCALE=1. Write addr0=8'hC0, fg=12'hFFF, bg=0, mode0. At frame pixel (0,0) and (1,0): RGB=F,F,F exactly 3 cycles
//    after the input; at (2,0): RGB=0.
//  3 clear_req pulse -> clear_busy high exactly 38400 cycles, wr_ready low; held wr_valid accepted on the first cycle
//    after; readback via display is all bg.
//  4 Change mode to INVERT mid-frame -> current frame unchanged; next frame pixel (0,0)=bg, (2,0)=fg.
//  5 SCALE=2, write addr0=8'h80 -> screen pixels (0..1,0..1) are fg and (2,0) is bg. wr_addr=9600 (OOB) is accepted,
//    no RAM change.
//  6 Reset asserted 100 cycles into a clear -> clear_busy=0 next cycle; a new clear_req runs the full FB_BYTES cycles.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and defaults for the framebuffer pixel pipeline.
package vga_pkg;

   localparam int H_ACTIVE_DEF = 640;
   localparam int V_ACTIVE_DEF = 480;

   typedef enum logic [1:0] {
      BITMAP   = 2'd0,
      INVERT   = 2'd1,
      CHECKER  = 2'd2,
      SOLID_BG = 2'd3
   } mode_t;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } color_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   function automatic color_t pick_color(input logic sel, input color_t when_set, input color_t when_clr);
      return sel ? when_set : when_clr;
   endfunction

endpackage

// File: rtl/fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read port.
// A read and write to the same address on the same edge returns the old data.
module fb_ram #(
   parameter int DEPTH = 38400,
   parameter int WIDTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/vga_fb_pixel_pipe.sv
// 1bpp framebuffer pixel path: scaled fetch, fg/bg colouring with per-frame shadows,
// a clear engine and a valid/ready write port, with syncs delayed to match the 3-stage colour path.
module vga_fb_pixel_pipe
   import vga_pkg::*;
#(
   parameter int   H_ACTIVE  = H_ACTIVE_DEF,
   parameter int   V_ACTIVE  = V_ACTIVE_DEF,
   parameter int   SCALE     = 1,
   parameter logic SYNC_IDLE = 1'b1,
   localparam int  FB_W      = H_ACTIVE / SCALE,
   localparam int  FB_H      = V_ACTIVE / SCALE,
   localparam int  ROW_B     = FB_W / 8,
   localparam int  FB_BYTES  = ROW_B * FB_H,
   localparam int  ADDR_W    = $clog2(FB_BYTES)
) (
   input  logic              CLK_25,
   input  logic              Reset,
   input  logic [9:0]        pixel_x,
   input  logic [9:0]        pixel_y,
   input  logic              in_display,
   input  logic              h_sync_in,
   input  logic              v_sync_in,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [7:0]        wr_data,
   input  logic              clear_req,
   output logic              clear_busy,
   input  logic [1:0]        mode,
   input  logic [11:0]       fg_color,
   input  logic [11:0]       bg_color,
   output logic [3:0]        RED,
   output logic [3:0]        GREEN,
   output logic [3:0]        BLUE,
   output logic              h_sync,
   output logic              v_sync
);

   localparam int SH = $clog2(SCALE);

   logic [9:0]        fb_x, fb_y;
   logic              in_area;
   logic [ADDR_W-1:0] rd_addr;

   logic [ADDR_W-1:0] addr_q1;
   logic [2:0]        bit_q1, bit_q2;
   logic              chk_q1, chk_q2;
   logic              disp_q1, disp_q2;
   logic              hs_q1, hs_q2, vs_q1, vs_q2;

   mode_t             mode_sh;
   color_t            fg_sh, bg_sh, color_next;
   logic              pix;

   clr_state_t        state;
   logic [ADDR_W-1:0] clr_addr;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [7:0]        ram_wdata, ram_q;

   // Off-screen coordinates fetch byte 0 so the RAM index always stays in range.
   always_comb begin
      fb_x    = pixel_x >> SH;
      fb_y    = pixel_y >> SH;
      in_area = (32'(pixel_x) < H_ACTIVE) && (32'(pixel_y) < V_ACTIVE);
      rd_addr = '0;
      if (in_area) begin
         rd_addr = ADDR_W'(fb_y) * ADDR_W'(ROW_B) + ADDR_W'(fb_x[9:3]);
      end
   end

   always_ff @(posedge CLK_25) begin
      if (Reset) begin
         addr_q1 <= '0;
         bit_q1  <= '0;
         chk_q1  <= 1'b0;
         disp_q1 <= 1'b0;
         hs_q1   <= SYNC_IDLE;
         vs_q1   <= SYNC_IDLE;
         bit_q2  <= '0;
         chk_q2  <= 1'b0;
         disp_q2 <= 1'b0;
         hs_q2   <= SYNC_IDLE;
         vs_q2   <= SYNC_IDLE;
         RED     <= '0;
         GREEN   <= '0;
         BLUE    <= '0;
         h_sync  <= SYNC_IDLE;
         v_sync  <= SYNC_IDLE;
      end else begin
         addr_q1 <= rd_addr;
         bit_q1  <= fb_x[2:0];
         chk_q1  <= fb_x[3] ^ fb_y[3];
         disp_q1 <= in_display;
         hs_q1   <= h_sync_in;
         vs_q1   <= v_sync_in;
         bit_q2  <= bit_q1;
         chk_q2  <= chk_q1;
         disp_q2 <= disp_q1;
         hs_q2   <= hs_q1;
         vs_q2   <= vs_q1;
         RED     <= color_next.r;
         GREEN   <= color_next.g;
         BLUE    <= color_next.b;
         h_sync  <= hs_q2;
         v_sync  <= vs_q2;
      end
   end

   // Mode and colours only change at frame start so a frame never renders with mixed settings.
   always_ff @(posedge CLK_25) begin
      if (Reset) begin
         mode_sh <= BITMAP;
         fg_sh   <= '0;
         bg_sh   <= '0;
      end else if (pixel_x == 10'd0 && pixel_y == 10'd0) begin
         mode_sh <= mode_t'(mode);
         fg_sh   <= color_t'(fg_color);
         bg_sh   <= color_t'(bg_color);
      end
   end

   always_comb begin
      pix = ram_q[3'd7 - bit_q2];
      case (mode_sh)
         BITMAP:  color_next = pick_color(pix, fg_sh, bg_sh);
         INVERT:  color_next = pick_color(pix, bg_sh, fg_sh);
         CHECKER: color_next = pick_color(chk_q2, fg_sh, bg_sh);
         default: color_next = bg_sh;
      endcase
      if (!disp_q2) begin
         color_next = '0;
      end
   end

   always_ff @(posedge CLK_25) begin
      if (Reset) begin
         state      <= IDLE;
         clr_addr   <= '0;
         clear_busy <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (clear_req) begin
                  state      <= CLEAR;
                  clr_addr   <= '0;
                  clear_busy <= 1'b1;
               end
            end
            CLEAR: begin
               if (clr_addr == ADDR_W'(FB_BYTES - 1)) begin
                  state      <= IDLE;
                  clr_addr   <= '0;
                  clear_busy <= 1'b0;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            default: begin
               state      <= IDLE;
               clr_addr   <= '0;
               clear_busy <= 1'b0;
            end
         endcase
      end
   end

   assign wr_ready = ~clear_busy;

   // The clear engine owns the write port while busy; out-of-range writes are accepted but dropped.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = wr_addr;
      ram_wdata = wr_data;
      if (state == CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_addr;
         ram_wdata = 8'h00;
      end else if (wr_valid && (32'(wr_addr) < FB_BYTES)) begin
         ram_we = 1'b1;
      end
   end

   fb_ram #(
      .DEPTH (FB_BYTES),
      .WIDTH (8),
      .AW    (ADDR_W)
   ) u_fb_ram (
      .clk   (CLK_25),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (addr_q1),
      .rdata (ram_q)
   );

endmodule
